// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared cache-engine/BedRock definitions used by the command arbiter
// Provides the arbiter FSM state enum and the stall counter width.
package bp_common_pkg;
    typedef enum logic {e_arb_idle, e_arb_locked} bp_me_cmd_arb_state_e;
    localparam int stall_cnt_width_gp = 32;
endpackage

// File: rtl/bp_me_cmd_arb_id_fifo.sv
// bp_me_cmd_arb_id_fifo: 1-bit requester-id FIFO tracking outstanding transactions
// Ports: clk_i, reset_n_i (async active-low); v_i/data_i push; yumi_i pop;
//        data_o head entry, full_o, empty_o.
// Caller never pushes while full unless popping in the same cycle.
module bp_me_cmd_arb_id_fifo #(
    parameter int els_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic v_i,
    input  logic data_i,
    input  logic yumi_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int ptr_w = els_p > 1 ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    logic [els_p-1:0] mem;
    logic [ptr_w-1:0] rptr, wptr;
    logic [cnt_w-1:0] cnt;
    function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (v_i) wptr <= inc(wptr);
            if (yumi_i) rptr <= inc(rptr);
            cnt <= cnt + cnt_w'(v_i) - cnt_w'(yumi_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (v_i) mem[wptr] <= data_i;
    end
    always_comb begin
        data_o  = mem[rptr];
        full_o  = cnt == cnt_w'(els_p);
        empty_o = cnt == '0;
    end
endmodule

// File: rtl/bp_me_bedrock_cmd_arb.sv
// bp_me_bedrock_cmd_arb: 2:1 round-robin BedRock command arbiter with id-ordered response routing
// Ports: clk_i, reset_n_i (async active-low)
//        cmd{0,1}_* requester command streams in, cmd_* merged command stream out
//        rsp_* downstream response stream in, rsp{0,1}_* routed responses out
//        stall{0,1}_cnt_o saturating stall counters, only with BP_ME_CMD_ARB_STALL_CNT_EN
module bp_me_bedrock_cmd_arb
    import bp_common_pkg::*;
#(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int id_fifo_els_p  = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] cmd0_header_i,
    input  logic [data_width_p-1:0]   cmd0_data_i,
    input  logic                      cmd0_last_i,
    input  logic                      cmd0_v_i,
    output logic                      cmd0_ready_and_o,
    input  logic [header_width_p-1:0] cmd1_header_i,
    input  logic [data_width_p-1:0]   cmd1_data_i,
    input  logic                      cmd1_last_i,
    input  logic                      cmd1_v_i,
    output logic                      cmd1_ready_and_o,
    output logic [header_width_p-1:0] cmd_header_o,
    output logic [data_width_p-1:0]   cmd_data_o,
    output logic                      cmd_last_o,
    output logic                      cmd_v_o,
    input  logic                      cmd_ready_and_i,
    input  logic [header_width_p-1:0] rsp_header_i,
    input  logic [data_width_p-1:0]   rsp_data_i,
    input  logic                      rsp_last_i,
    input  logic                      rsp_v_i,
    output logic                      rsp_ready_and_o,
    output logic [header_width_p-1:0] rsp0_header_o,
    output logic [data_width_p-1:0]   rsp0_data_o,
    output logic                      rsp0_last_o,
    output logic                      rsp0_v_o,
    input  logic                      rsp0_ready_and_i,
    output logic [header_width_p-1:0] rsp1_header_o,
    output logic [data_width_p-1:0]   rsp1_data_o,
    output logic                      rsp1_last_o,
    output logic                      rsp1_v_o,
    input  logic                      rsp1_ready_and_i
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
    ,
    output logic [stall_cnt_width_gp-1:0] stall0_cnt_o,
    output logic [stall_cnt_width_gp-1:0] stall1_cnt_o
`endif
);
    bp_me_cmd_arb_state_e state_r, state_n;
    logic owner_r, last_grant_r, gnt, allow, hs, first, pop;
    logic fifo_full, fifo_empty, fifo_head;
    bp_me_cmd_arb_id_fifo #(.els_p(id_fifo_els_p)) id_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (first),
        .data_i   (gnt),
        .yumi_i   (pop),
        .data_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );
    // A full FIFO still admits a new message when a slot frees up in the same cycle.
    // The pop depends only on the response side, so there is no loop through the cmd path.
    always_comb begin
        gnt = (state_r == e_arb_locked) ? owner_r
            : (cmd0_v_i & cmd1_v_i) ? ~last_grant_r : cmd1_v_i;
        allow = reset_n_i & ((state_r == e_arb_locked) | ~fifo_full | pop);
        cmd_header_o = gnt ? cmd1_header_i : cmd0_header_i;
        cmd_data_o = gnt ? cmd1_data_i : cmd0_data_i;
        cmd_last_o = gnt ? cmd1_last_i : cmd0_last_i;
        cmd_v_o = allow & (gnt ? cmd1_v_i : cmd0_v_i);
        cmd0_ready_and_o = allow & ~gnt & cmd_ready_and_i;
        cmd1_ready_and_o = allow & gnt & cmd_ready_and_i;
        hs = cmd_v_o & cmd_ready_and_i;
        first = hs & (state_r == e_arb_idle);
        rsp_ready_and_o = reset_n_i & ~fifo_empty & (fifo_head ? rsp1_ready_and_i : rsp0_ready_and_i);
        rsp0_v_o = reset_n_i & rsp_v_i & ~fifo_empty & ~fifo_head;
        rsp1_v_o = reset_n_i & rsp_v_i & ~fifo_empty & fifo_head;
        pop = rsp_v_i & rsp_ready_and_o & rsp_last_i;
        rsp0_header_o = rsp_header_i;
        rsp0_data_o = rsp_data_i;
        rsp0_last_o = rsp_last_i;
        rsp1_header_o = rsp_header_i;
        rsp1_data_o = rsp_data_i;
        rsp1_last_o = rsp_last_i;
    end
    always_comb begin
        state_n = state_r;
        if (hs) state_n = cmd_last_o ? e_arb_idle : e_arb_locked;
    end
    // last_grant starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_arb_idle;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_n;
            if (first) begin
                owner_r      <= gnt;
                last_grant_r <= gnt;
            end
        end
    end
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall0_cnt_o <= '0;
            stall1_cnt_o <= '0;
        end else begin
            if (cmd0_v_i & ~cmd0_ready_and_o & ~&stall0_cnt_o) stall0_cnt_o <= stall0_cnt_o + 1'b1;
            if (cmd1_v_i & ~cmd1_ready_and_o & ~&stall1_cnt_o) stall1_cnt_o <= stall1_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bp_me_bedrock_cmd_arb.sv
// tb_bp_me_bedrock_cmd_arb: directed scoreboard bench for the BedRock command arbiter
module tb_bp_me_bedrock_cmd_arb;
    logic clk = 1'b1;
    logic reset_n_i = 1'b0;
    logic [63:0] cmd0_header_i = '0, cmd0_data_i = '0, cmd1_header_i = '0, cmd1_data_i = '0;
    logic cmd0_last_i = 0, cmd0_v_i = 0, cmd1_last_i = 0, cmd1_v_i = 0;
    logic cmd0_ready_and_o, cmd1_ready_and_o;
    logic [63:0] cmd_header_o, cmd_data_o;
    logic cmd_last_o, cmd_v_o;
    logic cmd_ready_and_i = 1'b1;
    logic [63:0] rsp_header_i = '0, rsp_data_i = '0;
    logic rsp_last_i = 0, rsp_v_i = 0, rsp_ready_and_o;
    logic [63:0] rsp0_header_o, rsp0_data_o, rsp1_header_o, rsp1_data_o;
    logic rsp0_last_o, rsp0_v_o, rsp1_last_o, rsp1_v_o;
    logic rsp0_ready_and_i = 1'b1, rsp1_ready_and_i = 1'b1;
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
    logic [31:0] stall0_cnt_o, stall1_cnt_o;
`endif

    always #5 clk = ~clk;

    bp_me_bedrock_cmd_arb dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .cmd0_header_i(cmd0_header_i), .cmd0_data_i(cmd0_data_i), .cmd0_last_i(cmd0_last_i),
        .cmd0_v_i(cmd0_v_i), .cmd0_ready_and_o(cmd0_ready_and_o),
        .cmd1_header_i(cmd1_header_i), .cmd1_data_i(cmd1_data_i), .cmd1_last_i(cmd1_last_i),
        .cmd1_v_i(cmd1_v_i), .cmd1_ready_and_o(cmd1_ready_and_o),
        .cmd_header_o(cmd_header_o), .cmd_data_o(cmd_data_o), .cmd_last_o(cmd_last_o),
        .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i),
        .rsp_header_i(rsp_header_i), .rsp_data_i(rsp_data_i), .rsp_last_i(rsp_last_i),
        .rsp_v_i(rsp_v_i), .rsp_ready_and_o(rsp_ready_and_o),
        .rsp0_header_o(rsp0_header_o), .rsp0_data_o(rsp0_data_o), .rsp0_last_o(rsp0_last_o),
        .rsp0_v_o(rsp0_v_o), .rsp0_ready_and_i(rsp0_ready_and_i),
        .rsp1_header_o(rsp1_header_o), .rsp1_data_o(rsp1_data_o), .rsp1_last_o(rsp1_last_o),
        .rsp1_v_o(rsp1_v_o), .rsp1_ready_and_i(rsp1_ready_and_i)
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
        , .stall0_cnt_o(stall0_cnt_o), .stall1_cnt_o(stall1_cnt_o)
`endif
    );

    // scoreboard entries: {port, header, last}
    logic [65:0] exp_cmd[$];
    logic [65:0] exp_rsp[$];
    // per-cycle direct checks, bits {cmd_v, cmd0_rdy, cmd1_rdy, rsp_rdy, rsp0_v, rsp1_v}
    logic [5:0] chk_m = '0, chk_v = '0;
    string chk_n = "";
    logic chk_stall = 0, done = 0;
    int total = 0, bad = 0;

    always @(negedge clk) begin
        logic [5:0] obs;
        logic [65:0] e;
        logic [63:0] rh, rd;
        obs = {cmd_v_o, cmd0_ready_and_o, cmd1_ready_and_o, rsp_ready_and_o, rsp0_v_o, rsp1_v_o};
        if (chk_m != '0) begin
            total++;
            if ((obs & chk_m) != (chk_v & chk_m)) begin
                bad++;
                $display("FAIL %s: got %b want %b (mask %b)", chk_n, obs, chk_v, chk_m);
            end
        end
        if (cmd_v_o && cmd_ready_and_i) begin
            total++;
            if (exp_cmd.size() == 0) begin
                bad++;
                $display("FAIL cmd_extra: got hdr %h with no beat expected", cmd_header_o);
            end else begin
                e = exp_cmd.pop_front();
                if ({cmd1_ready_and_o, cmd_header_o, cmd_last_o} != e
                    || cmd0_ready_and_o == cmd1_ready_and_o || cmd_data_o != ~e[64:1]) begin
                    bad++;
                    $display("FAIL cmd_beat: got rdy %b%b hdr %h last %b data %h, want port %b hdr %h last %b",
                             cmd0_ready_and_o, cmd1_ready_and_o, cmd_header_o, cmd_last_o, cmd_data_o,
                             e[65], e[64:1], e[0]);
                end
            end
        end
        if (rsp_v_i && rsp_ready_and_o) begin
            total++;
            rh = rsp1_v_o ? rsp1_header_o : rsp0_header_o;
            rd = rsp1_v_o ? rsp1_data_o : rsp0_data_o;
            if (exp_rsp.size() == 0) begin
                bad++;
                $display("FAIL rsp_extra: got hdr %h with no response expected", rsp_header_i);
            end else begin
                e = exp_rsp.pop_front();
                if ({rsp1_v_o, rh, rsp1_v_o ? rsp1_last_o : rsp0_last_o} != e
                    || rsp0_v_o == rsp1_v_o || rd != ~e[64:1]) begin
                    bad++;
                    $display("FAIL rsp_route: got v %b%b hdr %h data %h, want port %b hdr %h last %b",
                             rsp0_v_o, rsp1_v_o, rh, rd, e[65], e[64:1], e[0]);
                end
            end
        end
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
        if (chk_stall) begin
            total++;
            if (stall0_cnt_o != 32'd0 || stall1_cnt_o != 32'd10) begin
                bad++;
                $display("FAIL stall_cnt: got %0d/%0d want 0/10", stall0_cnt_o, stall1_cnt_o);
            end
        end
`endif
        if (done) begin
            total++;
            if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d cmd / %0d rsp pending want 0/0", exp_cmd.size(), exp_rsp.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_m = '0;
        chk_stall = 0;
    endtask
    task automatic c0(input logic v, input logic [63:0] h, input logic l);
        cmd0_v_i = v; cmd0_header_i = h; cmd0_data_i = ~h; cmd0_last_i = l;
    endtask
    task automatic c1(input logic v, input logic [63:0] h, input logic l);
        cmd1_v_i = v; cmd1_header_i = h; cmd1_data_i = ~h; cmd1_last_i = l;
    endtask
    task automatic rs(input logic v, input logic [63:0] h, input logic l);
        rsp_v_i = v; rsp_header_i = h; rsp_data_i = ~h; rsp_last_i = l;
    endtask
    task automatic ck(input string n, input logic [5:0] m, input logic [5:0] v);
        chk_n = n; chk_m = m; chk_v = v;
    endtask

    initial begin
        // reset: every valid/ready output held low regardless of inputs
        c0(1, 64'h1, 1); c1(1, 64'h2, 1); rs(1, 64'h3, 1);
        ck("reset_outputs", 6'b111111, 6'b000000);
        step();
        reset_n_i = 1'b1;
        rs(0, 0, 0);
        // round-robin with single-beat messages: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            c0(1, 64'hA0 + 64'(i), 1); c1(1, 64'hB0 + 64'(i), 1);
            if (i % 2 == 0) exp_cmd.push_back({1'b0, 64'hA0 + 64'(i), 1'b1});
            else exp_cmd.push_back({1'b1, 64'hB0 + 64'(i), 1'b1});
            ck("rr_grant", 6'b011000, (i % 2 == 0) ? 6'b010000 : 6'b001000);
            step();
        end
        // FIFO full: a new command is held off
        c1(0, 0, 0); c0(1, 64'hC9, 1);
        ck("full_block0", 6'b111100, 6'b000100);
        step();
        ck("full_block1", 6'b111100, 6'b000100);
        step();
        // one response frees a slot; the command is granted the following cycle
        c0(0, 0, 0); rs(1, 64'h50, 1);
        exp_rsp.push_back({1'b0, 64'h50, 1'b1});
        ck("rsp_route0", 6'b000011, 6'b000010);
        step();
        rs(0, 0, 0); c0(1, 64'hC0, 1);
        exp_cmd.push_back({1'b0, 64'hC0, 1'b1});
        ck("grant_after_pop", 6'b110000, 6'b110000);
        step();
        // full FIFO: pop and push in the same cycle
        c0(0, 0, 0); c1(1, 64'hD0, 1); rs(1, 64'h51, 1);
        exp_cmd.push_back({1'b1, 64'hD0, 1'b1});
        exp_rsp.push_back({1'b1, 64'h51, 1'b1});
        ck("push_pop_full", 6'b001011, 6'b001001);
        step();
        c1(0, 0, 0); rs(0, 0, 0); c0(1, 64'hC8, 1);
        ck("still_full", 6'b110000, 6'b000000);
        step();
        // drain in order 0,1,0,1
        c0(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rs(1, 64'h52 + 64'(i), 1);
            exp_rsp.push_back({i[0], 64'h52 + 64'(i), 1'b1});
            step();
        end
        // empty FIFO: responses are refused
        rs(1, 64'h5F, 1);
        ck("empty_rsp_block", 6'b000111, 6'b000000);
        step();
        rs(0, 0, 0);
        // 4-beat lock on port 0 with port 1 waiting
        c1(1, 64'hF0, 1);
        for (int i = 0; i < 4; i++) begin
            c0(1, 64'hE0 + 64'(i), i == 3);
            exp_cmd.push_back({1'b0, 64'hE0 + 64'(i), i == 3});
            ck("lock_hold", 6'b011000, 6'b010000);
            step();
        end
        c0(0, 0, 0);
        exp_cmd.push_back({1'b1, 64'hF0, 1'b1});
        ck("after_lock", 6'b001000, 6'b001000);
        step();
        c1(0, 0, 0);
        rs(1, 64'h60, 0); exp_rsp.push_back({1'b0, 64'h60, 1'b0});
        step();
        rs(1, 64'h61, 1); exp_rsp.push_back({1'b0, 64'h61, 1'b1});
        step();
        rs(1, 64'h62, 1); exp_rsp.push_back({1'b1, 64'h62, 1'b1});
        step();
        rs(0, 0, 0);
        // reset on beat 2 of a 3-beat message
        c0(1, 64'h70, 0);
        exp_cmd.push_back({1'b0, 64'h70, 1'b0});
        step();
        c0(1, 64'h71, 0); c1(1, 64'h81, 1);
        reset_n_i = 1'b0;
        ck("mid_msg_reset", 6'b111111, 6'b000000);
        step();
        step();
        reset_n_i = 1'b1;
        c0(1, 64'h72, 1); c1(1, 64'h82, 1);
        exp_cmd.push_back({1'b0, 64'h72, 1'b1});
        ck("post_reset_tie", 6'b111000, 6'b110000);
        step();
        c0(0, 0, 0); c1(0, 0, 0);
        rs(1, 64'h63, 1); exp_rsp.push_back({1'b0, 64'h63, 1'b1});
        step();
        rs(0, 0, 0);
`ifdef BP_ME_CMD_ARB_STALL_CNT_EN
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        c0(1, 64'h90, 0);
        exp_cmd.push_back({1'b0, 64'h90, 1'b0});
        step();
        c1(1, 64'hA9, 1);
        for (int i = 1; i <= 10; i++) begin
            c0(1, 64'h90 + 64'(i), i == 10);
            exp_cmd.push_back({1'b0, 64'h90 + 64'(i), i == 10});
            step();
        end
        c0(0, 0, 0); c1(0, 0, 0);
        chk_stall = 1;
        rs(1, 64'h64, 1); exp_rsp.push_back({1'b0, 64'h64, 1'b1});
        step();
        rs(0, 0, 0);
`endif
        step();
        done = 1;
    end
endmodule

// File: doc/bp_me_bedrock_cmd_arb.md
BP_ME_BEDROCK_CMD_ARB -- requirements
Module: bp_me_bedrock_cmd_arb

Interface
REQ-001 SHALL have parameter header_width_p, default 64: width of the BedRock mem header.
REQ-002 SHALL have parameter data_width_p, default 64: width of one stream beat.
REQ-003 SHALL have parameter id_fifo_els_p, default 4: maximum number of outstanding transactions.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports cmd{0,1}_header_i, cmd{0,1}_data_i, cmd{0,1}_last_i, cmd{0,1}_v_i (inputs) and cmd{0,1}_ready_and_o (output): requester command streams, widths as parameterised.
REQ-007 SHALL have ports cmd_header_o, cmd_data_o, cmd_last_o, cmd_v_o (outputs) and cmd_ready_and_i (input): the merged downstream command stream.
REQ-008 SHALL have ports rsp_header_i, rsp_data_i, rsp_last_i, rsp_v_i (inputs) and rsp_ready_and_o (output): the downstream response stream.
REQ-009 SHALL have ports rsp{0,1}_header_o, rsp{0,1}_data_o, rsp{0,1}_last_o, rsp{0,1}_v_o (outputs) and rsp{0,1}_ready_and_i (inputs): the routed per-requester responses.

Function
REQ-010 SHALL implement the two-state FSM IDLE/LOCKED with an owner register; a handshake is v&ready_and in the same cycle.
REQ-011 In IDLE with the id FIFO not full, SHALL grant combinationally: the only valid requester if one is valid; if both are valid, the requester not equal to last_grant (round-robin).
REQ-012 In LOCKED, SHALL pass only the owner's stream to the output; the other requester's ready_and SHALL be 0.
REQ-013 A first-beat handshake with last=0 SHALL move IDLE->LOCKED; a handshake with last=1 SHALL return to IDLE on the next cycle. A single-beat message SHALL stay in IDLE.
REQ-014 On every first-beat handshake, SHALL push the granted id into the id FIFO and update last_grant.
REQ-015 While the id FIFO is full, SHALL start no new message; an already-locked message SHALL finish.
REQ-016 Output path: cmd_*_o mux from the grantee, cmd_v_o = grantee v, grantee ready_and = cmd_ready_and_i; zero added latency, no buffering.
REQ-017 Response path: the head of the id FIFO selects the destination; rsp{k}_v_o = rsp_v_i & (head==k) & fifo_nonempty; rsp_ready_and_o = the selected rsp{k}_ready_and_i.
REQ-018 With the id FIFO empty, SHALL hold rsp_ready_and_o at 0; a response arriving then is a protocol error.
REQ-019 A last-beat response handshake SHALL pop the id FIFO.
REQ-020 A push and a pop in the same cycle SHALL leave the count unchanged; this SHALL also apply when the FIFO is full.
REQ-021 Id FIFO read and write pointers SHALL wrap modulo id_fifo_els_p.

Reset
REQ-022 Asserting reset_n_i low SHALL asynchronously set: FSM=IDLE, last_grant=1 (so port 0 wins first), FIFO pointers and count = 0.
REQ-023 During reset, all v_o and ready_and_o outputs SHALL be 0.
REQ-024 Reset mid-message SHALL discard the message; no partial state SHALL survive.

Configuration
REQ-025 With BP_ME_CMD_ARB_STALL_CNT_EN defined, SHALL add outputs stall0_cnt_o and stall1_cnt_o (32 bits each).
REQ-026 Each stall counter SHALL increment when its cmd{k}_v_i=1 and cmd{k}_ready_and_o=0, saturate at all-ones, and reset to 0.
REQ-027 Without BP_ME_CMD_ARB_STALL_CNT_EN, these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-028 The FSM state enum bp_me_cmd_arb_state_e SHALL live in bp_common_pkg (cache engine pkgdef); the header layout SHALL use the existing bedrock pkgdef.
REQ-029 The id FIFO SHALL be the sub-module bp_me_cmd_arb_id_fifo (1-bit entries, depth id_fifo_els_p); the arbiter FSM SHALL be in the top level.

Verification
REQ-030 Both ports valid with single-beat messages from reset, cmd_ready_and_i=1: grants SHALL alternate 0,1,0,1; the FIFO SHALL hold 0,1,0,1.
REQ-031 Port 0 sends a 4-beat message while port 1 stays valid throughout: port 1 ready_and SHALL be 0 for all 4 beats; port 1 SHALL be granted in the cycle after beat 4.
REQ-032 With id_fifo_els_p=4, issue 4 single-beat commands with no responses: the 5th command SHALL see ready_and=0; after one last-beat response, it SHALL be granted the next cycle.
REQ-033 FIFO full, and on one cycle a response-last pop coincides with a new command grant: count SHALL stay 4 and the ordering SHALL be preserved.
REQ-034 Pull reset_n_i low on beat 2 of a 3-beat message: outputs SHALL drop to 0 immediately; after release the FSM SHALL be IDLE and port 0 SHALL win a tie.
REQ-035 With BP_ME_CMD_ARB_STALL_CNT_EN defined, hold port 1 valid for 10 cycles during a port 0 lock: stall1_cnt_o SHALL equal 10.
